asic_ioseq_vss: RTL and testbench

ASIC_IOSEQ_VSS -- requirements
Module: asic_ioseq_vss

---
 rtl/asic_ioseq_vss.sv | 170 +++++++++++++++++
 tb/tb_asic_ioseq_vss.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/asic_ioseq_vss.sv
// Power-ring IO sequencer: enables control-ring channels one at a time and waits
// for each acknowledge. Define ASIC_IOSEQ_TIMEOUT_EN to fault on a missing acknowledge.
module asic_ioseq_vss #(
   parameter     TYPE  = "SOFT",
   parameter     DIR   = "N",
   parameter int NCTRL = 8,
   parameter int DW    = 8
) (
   input  logic             clk,
   input  logic             reset,
   inout  wire              vddio,
   inout  wire              vssio,
   inout  wire              vdd,
   inout  wire              vss,
   input  logic             en,
   input  logic [DW-1:0]    cfg_delay,
   input  logic [DW-1:0]    cfg_timeout,
   input  logic [NCTRL-1:0] sense,
   output logic [NCTRL-1:0] ctrl,
   output logic             ready,
   output logic             busy,
   output logic             fault,
   output logic [4:0]       fault_idx
);

   localparam int IW = (NCTRL > 1) ? $clog2(NCTRL) : 1;
   localparam bit TYPE_SOFT = (TYPE == "SOFT");
   localparam bit DIR_NS    = (DIR == "N") || (DIR == "S");

   typedef enum logic [2:0] {S_IDLE, S_UP, S_ACK, S_ON, S_DOWN, S_FAULT} state_t;

   state_t           r_state;
   logic [IW-1:0]    r_idx;
   logic [DW-1:0]    r_cnt;
   logic [NCTRL-1:0] r_ctrl;
   logic             r_ready, r_busy, r_fault;
   logic [4:0]       r_fault_idx;
   logic [4:0]       w_drop_idx;
   logic             w_step;
   logic             w_last;

   // Supply pins and implementation tags carry no logic in the soft model.
   logic w_unused;
`ifdef ASIC_IOSEQ_TIMEOUT_EN
   assign w_unused = &{1'b0, vddio, vssio, vdd, vss, TYPE_SOFT, DIR_NS};
`else
   assign w_unused = &{1'b0, vddio, vssio, vdd, vss, TYPE_SOFT, DIR_NS, cfg_timeout};
`endif

   assign w_step = (r_cnt == cfg_delay);
   assign w_last = (r_idx == IW'(NCTRL-1));

   // Lowest channel whose acknowledge has dropped.
   always_comb begin
      w_drop_idx = '0;
      for (int i = NCTRL-1; i >= 0; i--)
         if (!sense[i]) w_drop_idx = 5'(i);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_idx       <= '0;
         r_cnt       <= '0;
         r_ctrl      <= '0;
         r_ready     <= 1'b0;
         r_busy      <= 1'b0;
         r_fault     <= 1'b0;
         r_fault_idx <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_ctrl <= '0;
               if (en) begin
                  r_state <= S_UP;
                  r_idx   <= '0;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
               end
            end
            S_UP: begin
               if (!en) begin
                  r_state <= S_DOWN;
                  r_cnt   <= '0;
               end else if (w_step) begin
                  r_ctrl[r_idx] <= 1'b1;
                  r_cnt         <= '0;
                  r_state       <= S_ACK;
               end else begin
                  r_cnt <= r_cnt + DW'(1);
               end
            end
            S_ACK: begin
               if (!en) begin
                  r_state <= S_DOWN;
                  r_cnt   <= '0;
               end else if (sense[r_idx]) begin
                  if (w_last) begin
                     r_state <= S_ON;
                     r_ready <= 1'b1;
                     r_busy  <= 1'b0;
                  end else begin
                     r_idx   <= r_idx + IW'(1);
                     r_cnt   <= '0;
                     r_state <= S_UP;
                  end
`ifdef ASIC_IOSEQ_TIMEOUT_EN
               // Compare the post-increment count so the fault lands cfg_timeout cycles after the enable.
               end else if (r_cnt + DW'(1) == cfg_timeout) begin
                  r_state     <= S_FAULT;
                  r_ctrl      <= '0;
                  r_busy      <= 1'b0;
                  r_fault     <= 1'b1;
                  r_fault_idx <= 5'(r_idx);
               end else begin
                  r_cnt <= r_cnt + DW'(1);
`endif
               end
            end
            S_ON: begin
               r_ctrl <= '1;
               if (!(&sense)) begin
                  r_state     <= S_FAULT;
                  r_ctrl      <= '0;
                  r_ready     <= 1'b0;
                  r_fault     <= 1'b1;
                  r_fault_idx <= w_drop_idx;
               end else if (!en) begin
                  r_state <= S_DOWN;
                  r_idx   <= IW'(NCTRL-1);
                  r_cnt   <= '0;
                  r_ready <= 1'b0;
                  r_busy  <= 1'b1;
               end
            end
            S_DOWN: begin
               if (w_step) begin
                  r_ctrl[r_idx] <= 1'b0;
                  r_cnt         <= '0;
                  if (r_idx == '0) begin
                     r_state <= S_IDLE;
                     r_busy  <= 1'b0;
                  end else begin
                     r_idx <= r_idx - IW'(1);
                  end
               end else begin
                  r_cnt <= r_cnt + DW'(1);
               end
            end
            S_FAULT: begin
               r_ctrl  <= '0;
               r_ready <= 1'b0;
               r_busy  <= 1'b0;
               if (!en) begin
                  r_state <= S_IDLE;
                  r_fault <= 1'b0;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign ctrl      = r_ctrl;
   assign ready     = r_ready;
   assign busy      = r_busy;
   assign fault     = r_fault;
   assign fault_idx = r_fault_idx;

endmodule

// File: tb/tb_asic_ioseq_vss.sv
// Directed bench for asic_ioseq_vss: 4 channels, delay 3, sense looped back from ctrl
// with a per-bit mask to emulate missing or dropped acknowledges.
module tb_asic_ioseq_vss;

   logic       clk = 1'b0;
   logic       reset;
   logic       en;
   logic [7:0] cfg_delay;
   logic [7:0] cfg_timeout;
   logic [3:0] sense;
   logic [3:0] sense_mask;
   logic [3:0] ctrl;
   logic       ready, busy, fault;
   logic [4:0] fault_idx;
   wire        vddio = 1'b1;
   wire        vssio = 1'b0;
   wire        vdd   = 1'b1;
   wire        vss   = 1'b0;

   int   n_chk = 0;
   int   n_err = 0;
   logic abort_win = 1'b0;
   logic ready_seen = 1'b0;

   asic_ioseq_vss #(.TYPE("SOFT"), .DIR("N"), .NCTRL(4), .DW(8)) dut (
      .clk(clk), .reset(reset),
      .vddio(vddio), .vssio(vssio), .vdd(vdd), .vss(vss),
      .en(en), .cfg_delay(cfg_delay), .cfg_timeout(cfg_timeout),
      .sense(sense), .ctrl(ctrl), .ready(ready), .busy(busy),
      .fault(fault), .fault_idx(fault_idx)
   );

   always #5 clk = ~clk;
   assign sense = ctrl & ~sense_mask;

   always @(negedge clk)
      if (abort_win && ready) ready_seen = 1'b1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; en = 1'b0; cfg_delay = 8'd3; cfg_timeout = 8'd10; sense_mask = 4'b0000;
      tick(2);
      chk("rst_ctrl", 32'(ctrl), 32'h0);
      chk("rst_ready", 32'(ready), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_fault", 32'(fault), 32'h0);
      chk("rst_fidx", 32'(fault_idx), 32'h0);

      // power-up: one channel every 5 cycles
      reset = 1'b0; en = 1'b1;
      tick(1);  chk("up_busy", 32'(busy), 32'h1);
      tick(4);  chk("up_c0", 32'(ctrl), 32'h1);
      tick(4);  chk("up_c0_hold", 32'(ctrl), 32'h1);
      tick(1);  chk("up_c1", 32'(ctrl), 32'h3);
      tick(5);  chk("up_c2", 32'(ctrl), 32'h7);
      tick(5);  chk("up_c3", 32'(ctrl), 32'hF);
      chk("up_rdy_early", 32'(ready), 32'h0);
      tick(1);  chk("on_ready", 32'(ready), 32'h1);
      chk("on_busy", 32'(busy), 32'h0);

      // power-down at 4-cycle spacing
      en = 1'b0;
      tick(1);  chk("dn_ready", 32'(ready), 32'h0);
      chk("dn_busy", 32'(busy), 32'h1);
      tick(4);  chk("dn_c3", 32'(ctrl), 32'h7);
      tick(4);  chk("dn_c2", 32'(ctrl), 32'h3);
      tick(4);  chk("dn_c1", 32'(ctrl), 32'h1);
      tick(4);  chk("dn_c0", 32'(ctrl), 32'h0);
      chk("dn_idle_busy", 32'(busy), 32'h0);

      // abort while waiting on channel 2's acknowledge
      sense_mask = 4'b0100; abort_win = 1'b1; en = 1'b1;
      tick(15); chk("ab_ack2", 32'(ctrl), 32'h7);
      en = 1'b0;
      tick(5);  chk("ab_c2", 32'(ctrl), 32'h3);
      en = 1'b1; sense_mask = 4'b0000;   // ignored until IDLE
      tick(4);  chk("ab_c1", 32'(ctrl), 32'h1);
      tick(4);  chk("ab_c0", 32'(ctrl), 32'h0);
      chk("ab_idle_busy", 32'(busy), 32'h0);
      abort_win = 1'b0;
      chk("ab_no_ready", 32'(ready_seen), 32'h0);
      tick(1);  chk("ab_restart", 32'(busy), 32'h1);
      tick(20); chk("re_ready", 32'(ready), 32'h1);

      // acknowledge drop while on
      sense_mask = 4'b0010;
      tick(1);  chk("f1_fault", 32'(fault), 32'h1);
      chk("f1_idx", 32'(fault_idx), 32'h1);
      chk("f1_ctrl", 32'(ctrl), 32'h0);
      chk("f1_ready", 32'(ready), 32'h0);
      tick(3);  chk("f1_sticky", 32'(fault), 32'h1);
      chk("f1_busy", 32'(busy), 32'h0);
      sense_mask = 4'b0000; en = 1'b0;
      tick(1);  chk("f1_clear", 32'(fault), 32'h0);

      // two channels drop: lowest index reported
      en = 1'b1;
      tick(21); chk("f2_on", 32'(ready), 32'h1);
      sense_mask = 4'b1100;
      tick(1);  chk("f2_idx", 32'(fault_idx), 32'h2);
      sense_mask = 4'b0000; en = 1'b0;
      tick(1);

      // channel 0 never acknowledges
      sense_mask = 4'b0001; en = 1'b1;
      tick(5);  chk("to_c0", 32'(ctrl), 32'h1);
`ifdef ASIC_IOSEQ_TIMEOUT_EN
      tick(9);  chk("to_before", 32'(fault), 32'h0);
      tick(1);  chk("to_fault", 32'(fault), 32'h1);
      chk("to_idx", 32'(fault_idx), 32'h0);
      chk("to_ctrl", 32'(ctrl), 32'h0);
`else
      tick(30); chk("hang_ctrl", 32'(ctrl), 32'h1);
      chk("hang_busy", 32'(busy), 32'h1);
      chk("hang_fault", 32'(fault), 32'h0);
`endif
      sense_mask = 4'b0000; en = 1'b0;
      tick(6);  chk("to_idle_ctrl", 32'(ctrl), 32'h0);
      chk("to_idle_busy", 32'(busy), 32'h0);
      chk("to_idle_fault", 32'(fault), 32'h0);

      // asynchronous reset in the middle of channel 2's up step
      en = 1'b1;
      tick(12); chk("ar_pre_ctrl", 32'(ctrl), 32'h3);
      chk("ar_pre_busy", 32'(busy), 32'h1);
      #2 reset = 1'b1;
      #1;
      chk("ar_ctrl", 32'(ctrl), 32'h0);
      chk("ar_busy", 32'(busy), 32'h0);
      en = 1'b0;
      tick(1);  reset = 1'b0;
      tick(2);  chk("ar_idle", 32'(busy), 32'h0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
